// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//   Multi-channel clock-enable generator. Each channel runs a modulo-div
//   counter and emits a one-cycle clock-enable pulse plus a divided square
//   wave. A small FSM (SETTLE / LOCKED / APPLY) realigns all channels on a
//   configuration write or a sync request and reports when the channels have
//   been aligned for LOCK_CYCLES cycles.
//
//   Optional feature macro: CLKGEN_PHASE_EN
//     defined   -> cfg_phase port present; per-channel phase offset stored
//     undefined -> no cfg_phase port, all channels zero-phase
//
// Parameters
//   NUM_CH      number of output channels (1..16)
//   DIV_W       width of divide ratio / phase fields
//   DIV_DEFAULT divide ratio loaded into every channel at reset
//   LOCK_CYCLES settle time in refclk cycles before locked asserts
//
// Ports
//   refclk     in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   cfg_valid  in   configuration request
//   cfg_ready  out  configuration accept (low during APPLY and out of reset)
//   cfg_ch     in   target channel; out-of-range writes only realign
//   cfg_div    in   new divide ratio (0 behaves as 1)
//   cfg_phase  in   new phase offset (CLKGEN_PHASE_EN only)
//   sync       in   realign-all request
//   ce         out  per-channel clock-enable pulses
//   clk_out    out  per-channel divided square wave
//   locked     out  high only in LOCKED
// -----------------------------------------------------------------------------
module clk_enable_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DIV_DEFAULT = 4,
  parameter int unsigned LOCK_CYCLES = 64,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0]  cfg_phase,
`endif
  input  logic              sync,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int unsigned SET_W = ($clog2(LOCK_CYCLES + 1) > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    SETTLE,
    LOCKED,
    APPLY
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               ready_q, ready_d;
  logic               locked_q, locked_d;
  logic [NUM_CH-1:0]  ce_q, ce_d;
  logic [NUM_CH-1:0]  clk_q, clk_d;
  logic [DIV_W-1:0]   div_q [NUM_CH];
  logic [DIV_W-1:0]   div_d [NUM_CH];
  logic [DIV_W-1:0]   cnt_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_d [NUM_CH];
`ifdef CLKGEN_PHASE_EN
  logic [DIV_W-1:0]   phase_q [NUM_CH];
  logic [DIV_W-1:0]   phase_d [NUM_CH];
`endif

  logic accept;
  logic apply_go;
  logic settle_done;

  // A divide ratio of zero behaves exactly like one.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  // Number of high cycles per period: ceil(div/2).
  function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] e);
    return ({1'b0, e} + (DIV_W+1)'(1)) >> 1;
  endfunction

`ifdef CLKGEN_PHASE_EN
  // Starting the counter at div-phase delays the first ce by phase cycles.
  function automatic logic [DIV_W-1:0] reload_cnt(input logic [DIV_W-1:0] e,
                                                   input logic [DIV_W-1:0] ph);
    if ((ph == '0) || (ph >= e)) return '0;
    return e - ph;
  endfunction
`endif

  assign settle_done = (LOCK_CYCLES == 0) || (settle_q == SET_W'(LOCK_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control
  // ready_q is low only in APPLY and in the first cycle after reset. The
  // settle count is held during that first cycle so that locked rises
  // LOCK_CYCLES edges after the first edge, matching the timing that follows
  // an APPLY.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    apply_go = 1'b0;
    accept   = cfg_valid && ready_q;

    case (state_q)
      SETTLE: begin
        if (accept || sync) begin
          state_d  = APPLY;
          settle_d = '0;
          apply_go = 1'b1;
        end else if (ready_q) begin
          if (settle_done) begin
            state_d = LOCKED;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
      end
      LOCKED: begin
        if (accept || sync) begin
          state_d  = APPLY;
          settle_d = '0;
          apply_go = 1'b1;
        end
      end
      APPLY: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      default: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
    endcase

    ready_d  = (state_d != APPLY);
    locked_d = (state_d == LOCKED);
  end

  // ---------------------------------------------------------------------------
  // Channel datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    ce_d  = '0;
    clk_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
`ifdef CLKGEN_PHASE_EN
      phase_d[i] = phase_q[i];
`endif
      if (apply_go && accept && (cfg_ch == CH_W'(i))) begin
        div_d[i] = cfg_div;
`ifdef CLKGEN_PHASE_EN
        phase_d[i] = cfg_phase;
`endif
      end

      if (apply_go) begin
        // Reload uses the freshly written ratio so the new channel is aligned
        // with the others from its first pulse; outputs stay low in APPLY.
`ifdef CLKGEN_PHASE_EN
        cnt_d[i] = reload_cnt(eff_div(div_d[i]), phase_d[i]);
`else
        cnt_d[i] = '0;
`endif
        ce_d[i]  = 1'b0;
        clk_d[i] = 1'b0;
      end else begin
        if (cnt_q[i] >= (eff_div(div_q[i]) - DIV_W'(1))) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        ce_d[i]  = (cnt_q[i] == '0);
        clk_d[i] = ({1'b0, cnt_q[i]} < half_up(eff_div(div_q[i])));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      settle_q <= '0;
      ready_q  <= 1'b0;
      locked_q <= 1'b0;
      ce_q     <= '0;
      clk_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DIV_DEFAULT);
        cnt_q[i] <= '0;
`ifdef CLKGEN_PHASE_EN
        phase_q[i] <= '0;
`endif
      end
    end else begin
      settle_q <= settle_d;
      ready_q  <= ready_d;
      locked_q <= locked_d;
      ce_q     <= ce_d;
      clk_q    <= clk_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef CLKGEN_PHASE_EN
        phase_q[i] <= phase_d[i];
`endif
      end
    end
  end

  assign cfg_ready = ready_q;
  assign locked    = locked_q;
  assign ce        = ce_q;
  assign clk_out   = clk_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_gen
//   Self-checking bench for clk_enable_gen. The reference model describes each
//   channel by its divide ratio, phase and the cycle at which phase-0 channels
//   last realigned; expected outputs at any cycle follow from modular
//   arithmetic on the cycle number. Supports CLKGEN_PHASE_EN.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;

  localparam int NUM_CH  = 3;
  localparam int DIV_W   = 16;
  localparam int DIV_DEF = 4;
  localparam int LOCK    = 64;
  localparam int CH_W    = 2;
  localparam int OW      = 2 * NUM_CH + 2;
`ifdef CLKGEN_PHASE_EN
  localparam bit PHASE_EN = 1'b1;
`else
  localparam bit PHASE_EN = 1'b0;
`endif

  logic              refclk    = 1'b0;
  logic              rst       = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              sync      = 1'b0;
  logic [CH_W-1:0]   cfg_ch    = '0;
  logic [DIV_W-1:0]  cfg_div   = '0;
`ifdef CLKGEN_PHASE_EN
  logic [DIV_W-1:0]  cfg_phase = '0;
`endif
  logic              cfg_ready;
  logic              locked;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] clk_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_from = 1;
  int ref_div [NUM_CH];
  int ref_ph  [NUM_CH];

  clk_enable_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEF),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKGEN_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .sync      (sync),
    .ce        (ce),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int pmod(input int a, input int d);
    int r;
    r = a % d;
    if (r < 0) r += d;
    return r;
  endfunction

  // Packed as {locked, cfg_ready, clk_out, ce}.
  function automatic logic [OW-1:0] exp_vec();
    logic [NUM_CH-1:0] e_ce;
    logic [NUM_CH-1:0] e_clk;
    e_ce  = '0;
    e_clk = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int d;
      int ph;
      int pos;
      d   = (ref_div[i] == 0) ? 1 : ref_div[i];
      ph  = (ref_ph[i] >= d) ? 0 : ref_ph[i];
      pos = pmod(cyc - (valid_from + ph), d);
      e_ce[i]  = (cyc >= valid_from) && (pos == 0);
      e_clk[i] = (cyc >= valid_from) && (pos < (d + 1) / 2);
    end
    return {(cyc >= valid_from + LOCK), (cyc >= valid_from), e_clk, e_ce};
  endfunction

  // clk_out is left unconstrained during the APPLY cycle.
  function automatic logic [OW-1:0] msk_vec();
    if (cyc < valid_from) return {2'b11, {NUM_CH{1'b0}}, {NUM_CH{1'b1}}};
    return '1;
  endfunction

  function automatic logic [OW-1:0] obs();
    return {locked, cfg_ready, clk_out, ce};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      ref_div[i] = DIV_DEF;
      ref_ph[i]  = 0;
    end
    cyc        = 0;
    valid_from = 1;
  endtask

  task automatic step();
    @(posedge refclk);
    cyc++;
    #1;
  endtask

  // Presents one request in the current cycle (ready must be high), lets the
  // accepting edge pass, then withdraws it. Leaves the bench in the APPLY cycle.
  task automatic drive_apply(input bit v, input bit s, input int ch, input int dv, input int ph);
    cfg_valid = v;
    sync      = s;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
`ifdef CLKGEN_PHASE_EN
    cfg_phase = DIV_W'(ph);
`endif
    if (v && ch < NUM_CH) begin
      ref_div[ch] = dv;
      ref_ph[ch]  = PHASE_EN ? ph : 0;
    end
    valid_from = cyc + 2;
    step();
    cfg_valid = 1'b0;
    sync      = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", obs(), {OW{1'b0}});
    end
    repeat (3) @(posedge refclk);
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_held got=%b exp=%b", obs(), {OW{1'b0}});
    end
    #3 rst = 1'b1;
    cyc = 0;
    for (int c = 0; c < 90; c++) begin
      if (c > 0) step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
  endtask

  task automatic test_cfg_write();
    drive_apply(1'b1, 1'b0, 1, 10, 0);
    checks++;
    if ({cfg_ready, locked, ce} !== '0) begin
      errors++;
      $display("FAIL cfg_apply_cycle got=%b exp=%b", {cfg_ready, locked, ce}, {(NUM_CH+2){1'b0}});
    end
    for (int c = 0; c < 80; c++) begin
      step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL cfg_write cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
  endtask

  task automatic test_div_edges();
    drive_apply(1'b1, 1'b0, 0, 0, 0);
    step();
    drive_apply(1'b1, 1'b0, 2, 3, 0);
    for (int c = 0; c < 24; c++) begin
      step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL div_edges cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
    checks++;
    if (ce[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_const got=%b%b exp=11", ce[0], clk_out[0]);
    end
  endtask

  task automatic test_back_to_back();
    // Request held for two cycles; the second cycle falls in APPLY and its
    // changed divide ratio must not be taken.
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(2);
    cfg_div   = DIV_W'(5);
    ref_div[2] = 5;
    ref_ph[2]  = 0;
`ifdef CLKGEN_PHASE_EN
    cfg_phase = '0;
`endif
    valid_from = cyc + 2;
    step();
    cfg_div = DIV_W'(7);
    checks++;
    if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
      errors++;
      $display("FAIL b2b_apply cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
    end
    step();
    cfg_valid = 1'b0;
    for (int c = 0; c < 75; c++) begin
      if (c > 0) step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
  endtask

  task automatic test_sync();
    drive_apply(1'b1, 1'b1, 0, 6, 0);
    for (int c = 0; c < 75; c++) begin
      if (c > 0) step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL sync_cfg cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
    // sync held into the APPLY cycle must not cause a second APPLY.
    sync = 1'b1;
    valid_from = cyc + 2;
    step();
    step();
    sync = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL sync_hold cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
  endtask

  task automatic test_reset_mid_settle();
    drive_apply(1'b1, 1'b0, 1, 7, 0);
    repeat (10) step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs(), {OW{1'b0}});
    end
    @(posedge refclk);
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset_mid_held got=%b exp=%b", obs(), {OW{1'b0}});
    end
    #3 rst = 1'b1;
    model_reset();
    for (int c = 0; c < 80; c++) begin
      if (c > 0) step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL reset_recover cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
  endtask

`ifdef CLKGEN_PHASE_EN
  task automatic test_phase();
    drive_apply(1'b1, 1'b0, 1, 4, 2);
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL phase_lag2 cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
    drive_apply(1'b1, 1'b0, 1, 4, 5);
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL phase_big cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int kind;
      int wait_c;
      kind   = int'($urandom_range(0, 2));
      wait_c = (n % 5 == 4) ? 70 : int'($urandom_range(1, 25));
      drive_apply(kind != 1, kind != 0, int'($urandom_range(0, NUM_CH)),
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      checks++;
      if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
        errors++;
        $display("FAIL rand_apply cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
      end
      for (int c = 0; c < wait_c; c++) begin
        step();
        checks++;
        if ((obs() & msk_vec()) !== (exp_vec() & msk_vec())) begin
          errors++;
          $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs() & msk_vec(), exp_vec() & msk_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_div_edges();
    test_back_to_back();
    test_sync();
    test_reset_mid_settle();
`ifdef CLKGEN_PHASE_EN
    test_phase();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, giving the number of output channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 16, giving the width of the divide ratio and phase fields.
REQ-003 SHALL have parameter DIV_DEFAULT, default 4, giving the divide ratio loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CYCLES, default 64, giving the settle time in refclk cycles before locked asserts.
REQ-005 SHALL have port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cfg_valid, input, 1 bit: configuration request.
REQ-008 SHALL have port cfg_ready, output, 1 bit: configuration accept.
REQ-009 SHALL have port cfg_ch, input, max(1,clog2(NUM_CH)) bits: target channel.
REQ-010 SHALL have port cfg_div, input, DIV_W bits: new divide ratio.
REQ-011 SHALL have port cfg_phase, input, DIV_W bits: new phase offset, present only with CLKGEN_PHASE_EN.
REQ-012 SHALL have port sync, input, 1 bit: realign-all request.
REQ-013 SHALL have port ce, output, NUM_CH bits: per-channel clock-enable pulses.
REQ-014 SHALL have port clk_out, output, NUM_CH bits: per-channel divided square wave.
REQ-015 SHALL have port locked, output, 1 bit: all channels aligned and settled.

Function
REQ-016 SHALL run one modulo-div counter per channel; ce[i] high exactly one cycle every div[i] cycles.
REQ-017 SHALL drive clk_out[i] high for ceil(div[i]/2) cycles and low for floor(div[i]/2) cycles of each period, rising in the ce[i] cycle.
REQ-018 SHALL treat div=0 as div=1: ce[i] constant high, clk_out[i] constant high.
REQ-019 SHALL register all outputs; ce and clk_out change only on refclk rising edges.
REQ-020 SHALL implement FSM states SETTLE, LOCKED, APPLY: SETTLE->LOCKED after LOCK_CYCLES cycles; SETTLE or LOCKED -> APPLY on accepted cfg or sync; APPLY->SETTLE after one cycle.
REQ-021 SHALL accept cfg when cfg_valid and cfg_ready are both high in a cycle (T); cfg_ready is high in SETTLE and LOCKED and low in APPLY.
REQ-022 SHALL, at T+1 (APPLY), write div[cfg_ch], hold all ce low, drive locked low, and reload all counters together so every phase-0 channel pulses ce at T+2.
REQ-023 SHALL ignore writes whose cfg_ch >= NUM_CH, still performing the realignment.
REQ-024 SHALL treat sync high in SETTLE or LOCKED as an APPLY with no divider change; sync during APPLY is ignored.
REQ-025 SHALL, on cfg accept and sync in the same cycle, perform a single APPLY including the config write.
REQ-026 SHALL restart the settle count on every entry to SETTLE; locked is high only in LOCKED.

Reset
REQ-027 SHALL, while rst is low, asynchronously force ce=0, clk_out=0, locked=0, cfg_ready=0, every div to DIV_DEFAULT, every phase to 0, counters to 0, and the FSM to SETTLE.
REQ-028 SHALL emit the first ce pulse on all channels in the cycle after the first refclk edge following rst release, with locked rising LOCK_CYCLES cycles after that edge.
REQ-029 SHALL abort any operation in progress on reset assertion, including APPLY or SETTLE.

Configuration
REQ-030 SHALL, when CLKGEN_PHASE_EN is defined, store cfg_phase per channel on write so the channel's first post-APPLY ce pulse lags a phase-0 channel by phase cycles; phase >= div is treated as 0.
REQ-031 SHALL, when CLKGEN_PHASE_EN is undefined, omit the cfg_phase port and phase storage, with all channels zero-phase.

Verification
REQ-032 SHALL verify reset release with defaults: ce on all three channels pulses every 4 cycles, coincident; clk_out is 2 high / 2 low; locked rises 64 cycles after the first post-reset edge.
REQ-033 SHALL verify a write of cfg_ch=1, cfg_div=10: cfg_ready is low one cycle and locked drops; ch1 period is 10 and ch0/ch2 period is 4; all ce coincide at T+2; locked returns at T+2+64.
REQ-034 SHALL verify cfg_div=0 and cfg_div=3: ce is constant high for div=0; div=3 gives clk_out 2 high / 1 low.
REQ-035 SHALL verify sync and cfg_valid high in the same cycle: exactly one APPLY cycle, the new divider is active, and a single settle of 64 cycles follows.
REQ-036 SHALL verify rst asserted mid-SETTLE: all outputs are 0 within the same cycle without a clock edge, and recovery matches REQ-028.
REQ-037 SHALL verify, with CLKGEN_PHASE_EN, cfg_phase=2 on a div=4 channel: its ce lags ch0 by 2 cycles; cfg_phase=5 on the same channel gives zero lag.
